// File: rtl/fp_add_sub.sv
// fp_add_sub: multi-cycle IEEE-754 adder/subtractor with a fixed 4-cycle latency.
//
// Handshake: a Load sampled high on a rising Clk edge captures A, B and Op and
// starts an operation. Captured from any state, so a second Load aborts the
// operation in flight and restarts. Busy is high from the Load edge until the
// ROUND edge. On the ROUND edge Result is written and Valid rises. Result and
// Valid then stay stable until the next Load edge, which drops Valid.
//
// Ports:
//   Clk      rising-edge clock
//   RstN     asynchronous active-low reset
//   Load     request strobe
//   A, B     operands (PRECISION bits), captured on the Load edge
//   Op       0 = A+B, 1 = A-B, captured on the Load edge
//   Result   rounded result, round-to-nearest-even
//   Valid    result ready, held until the next Load
//   Busy     operation in flight
//   DbgState current FSM state (state_t encoding)
//
// Configuration macro: FP_ADD_SUBNORMAL_EN
//   defined     subnormal inputs are honoured; tiny results underflow gradually
//   not defined subnormal inputs read as signed zero; tiny results flush to zero
module fp_add_sub #(
  parameter int PRECISION = 32
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic                 Load,
  input  logic [PRECISION-1:0] A,
  input  logic [PRECISION-1:0] B,
  input  logic                 Op,
  output logic [PRECISION-1:0] Result,
  output logic                 Valid,
  output logic                 Busy,
  output logic [2:0]           DbgState
);
  localparam int EXP = (PRECISION == 64) ? 11 : 8;
  localparam int MAN = PRECISION - 1 - EXP;
  localparam int SW  = MAN + 4;  // hidden + fraction + guard/round/sticky
  localparam int EW  = EXP + 1;  // one spare bit to see exponent overflow
`ifdef FP_ADD_SUBNORMAL_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif
  localparam logic [EXP-1:0]       EMAX = '1;
  localparam logic [PRECISION-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MAN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;
  state_t r_state, w_next;

  // operand capture
  logic                 r_sa, r_sb, r_spec;
  logic [EXP-1:0]       r_xa, r_xb;
  logic [MAN:0]         r_siga, r_sigb;
  logic [PRECISION-1:0] r_spec_val;
  // datapath
  logic [SW-1:0]        r_m1, r_m2;
  logic [SW:0]          r_sum;
  logic [EW-1:0]        r_exp;
  logic                 r_sign, r_sub, r_zero;
  logic [PRECISION-1:0] r_result;
  logic                 r_valid;

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (Load) w_next = S_ALIGN;
  end

  // ---------------- classification on the Load edge ----------------
  logic                 w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic                 w_a_zero, w_b_zero, w_spec;
  logic [EXP-1:0]       w_ea, w_eb, w_xa, w_xb;
  logic [MAN-1:0]       w_fa, w_fb;
  logic [PRECISION-1:0] w_spec_val;

  always_comb begin
    w_sa = A[PRECISION-1];
    w_sb = B[PRECISION-1] ^ Op;
    w_ea = A[PRECISION-2 -: EXP];
    w_eb = B[PRECISION-2 -: EXP];
    // without subnormal support a zero exponent reads as zero whatever the fraction
    w_fa = (w_ea == '0 && !SUBN) ? '0 : A[MAN-1:0];
    w_fb = (w_eb == '0 && !SUBN) ? '0 : B[MAN-1:0];
    w_a_nan  = (w_ea == EMAX) && (w_fa != '0);
    w_b_nan  = (w_eb == EMAX) && (w_fb != '0);
    w_a_inf  = (w_ea == EMAX) && (w_fa == '0);
    w_b_inf  = (w_eb == EMAX) && (w_fb == '0);
    w_a_zero = (w_ea == '0) && (w_fa == '0);
    w_b_zero = (w_eb == '0) && (w_fb == '0);
    // subnormals sit at exponent 1 with a 0 hidden bit
    w_xa = (w_ea == '0) ? EXP'(1) : w_ea;
    w_xb = (w_eb == '0) ? EXP'(1) : w_eb;

    w_spec     = 1'b1;
    w_spec_val = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
      w_spec_val = QNAN;
    else if (w_a_inf)
      w_spec_val = {w_sa, EMAX, {MAN{1'b0}}};
    else if (w_b_inf)
      w_spec_val = {w_sb, EMAX, {MAN{1'b0}}};
    else if (w_a_zero && w_b_zero)
      w_spec_val = {w_sa & w_sb, {(PRECISION-1){1'b0}}};
    else
      w_spec = 1'b0;
  end

  // ---------------- ALIGN ----------------
  logic           w_a_big, w_big_s;
  logic [EXP-1:0] w_big_x, w_diff;
  logic [MAN:0]   w_big_sig, w_sml_sig;
  logic [SW-1:0]  w_sml_ext, w_shifted, w_sml_al;
  logic           w_lost;

  always_comb begin
    w_a_big   = {r_xa, r_siga} >= {r_xb, r_sigb};
    w_big_s   = w_a_big ? r_sa   : r_sb;
    w_big_x   = w_a_big ? r_xa   : r_xb;
    w_big_sig = w_a_big ? r_siga : r_sigb;
    w_sml_sig = w_a_big ? r_sigb : r_siga;
    w_diff    = w_a_big ? (r_xa - r_xb) : (r_xb - r_xa);
    w_sml_ext = {w_sml_sig, 3'b000};
    w_shifted = w_sml_ext >> w_diff;
    // every bit pushed past the sticky position is folded into sticky
    w_lost    = |(w_sml_ext & ~({SW{1'b1}} << w_diff));
    w_sml_al  = {w_shifted[SW-1:1], w_shifted[0] | w_lost};
  end

  // ---------------- NORM ----------------
  logic [EW-1:0] w_lzc, w_sh, w_nexp;
  logic [SW-1:0] w_nm;

  always_comb begin
    w_lzc = EW'(SW);
    for (int i = 0; i < SW; i++)
      if (r_sum[i]) w_lzc = EW'(SW - 1 - i);
    // never shift below exponent 1; what stays unnormalized is a subnormal
    w_sh = (w_lzc > r_exp - EW'(1)) ? (r_exp - EW'(1)) : w_lzc;
    if (r_sum[SW]) begin
      w_nm   = {r_sum[SW:2], r_sum[1] | r_sum[0]};
      w_nexp = r_exp + EW'(1);
    end else begin
      w_nm   = r_sum[SW-1:0] << w_sh;
      w_nexp = r_exp - w_sh;
    end
  end

  // ---------------- ROUND ----------------
  logic           w_inc, w_hid;
  logic [MAN+1:0] w_rnd;
  logic [EW-1:0]  w_rexp;
  logic [MAN-1:0] w_rfrac;

  always_comb begin
    w_inc   = r_m1[2] & (r_m1[3] | r_m1[1] | r_m1[0]);
    w_rnd   = {1'b0, r_m1[SW-1:3]} + {{(MAN+1){1'b0}}, w_inc};
    w_rexp  = r_exp + {{(EW-1){1'b0}}, w_rnd[MAN+1]};
    w_rfrac = w_rnd[MAN+1] ? '0 : w_rnd[MAN-1:0];
    w_hid   = |w_rnd[MAN+1:MAN];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_sa <= 1'b0; r_sb <= 1'b0; r_spec <= 1'b0;
      r_xa <= '0; r_xb <= '0; r_siga <= '0; r_sigb <= '0; r_spec_val <= '0;
      r_m1 <= '0; r_m2 <= '0; r_sum <= '0; r_exp <= '0;
      r_sign <= 1'b0; r_sub <= 1'b0; r_zero <= 1'b0;
      r_result <= '0; r_valid <= 1'b0;
    end else if (Load) begin
      r_sa       <= w_sa;
      r_sb       <= w_sb;
      r_xa       <= w_xa;
      r_xb       <= w_xb;
      r_siga     <= {w_ea != '0, w_fa};
      r_sigb     <= {w_eb != '0, w_fb};
      r_spec     <= w_spec;
      r_spec_val <= w_spec_val;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_ALIGN: begin
          r_m1   <= {w_big_sig, 3'b000};
          r_m2   <= w_sml_al;
          r_exp  <= {1'b0, w_big_x};
          r_sign <= w_big_s;
          r_sub  <= r_sa ^ r_sb;
        end
        S_ADD: begin
          r_sum <= r_sub ? ({1'b0, r_m1} - {1'b0, r_m2}) : ({1'b0, r_m1} + {1'b0, r_m2});
        end
        S_NORM: begin
          r_m1   <= w_nm;
          r_exp  <= w_nexp;
          r_zero <= (r_sum == '0);
        end
        S_ROUND: begin
          if (r_spec)
            r_result <= r_spec_val;
          else if (r_zero)
            r_result <= '0;
          else if (w_rexp >= {1'b0, EMAX})
            r_result <= {r_sign, EMAX, {MAN{1'b0}}};
          else if (!w_hid)
            r_result <= SUBN ? {r_sign, {EXP{1'b0}}, w_rfrac} : {r_sign, {(PRECISION-1){1'b0}}};
          else
            r_result <= {r_sign, w_rexp[EXP-1:0], w_rfrac};
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Result   = r_result;
  assign Valid    = r_valid;
  assign Busy     = (r_state != S_IDLE);
  assign DbgState = r_state;

endmodule

// File: tb/tb_fp_add_sub.sv
// Bench for fp_add_sub (PRECISION=32). Expected results come from an exact
// integer model: finite operands become integers in units of 2^-149, are added
// exactly, and the sum is rounded to nearest-even into binary32.
module tb_fp_add_sub;
  logic        Clk, RstN, Load, Op, Valid, Busy;
  logic [31:0] A, B, Result;
  logic [2:0]  DbgState;
  int          n_cmp, n_err;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  fp_add_sub #(.PRECISION(32)) dut (
    .Clk(Clk), .RstN(RstN), .Load(Load), .A(A), .B(B), .Op(Op),
    .Result(Result), .Valid(Valid), .Busy(Busy), .DbgState(DbgState)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [299:0] to_units(input logic [31:0] x);
    logic [299:0] u;
    u = '0;
    if (x[30:23] == 8'd0) begin
`ifdef FP_ADD_SUBNORMAL_EN
      u[22:0] = x[22:0];
`endif
    end else begin
      u[23:0] = {1'b1, x[22:0]};
      u = u << (x[30:23] - 1);
    end
    return u;
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
    logic         sa, sb, sr, a_nan, b_nan, a_inf, b_inf;
    logic [299:0] ua, ub, mag, q, rem, half;
    int           p, sh, e;
    sa    = a[31];
    sb    = b[31] ^ op;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return QNAN;
    if (a_inf && b_inf) return (sa == sb) ? {sa, 8'hFF, 23'd0} : QNAN;
    if (a_inf) return {sa, 8'hFF, 23'd0};
    if (b_inf) return {sb, 8'hFF, 23'd0};
    ua = to_units(a);
    ub = to_units(b);
    if (ua == 0 && ub == 0) return {sa & sb, 31'd0};
    if (sa == sb)      begin mag = ua + ub; sr = sa; end
    else if (ua >= ub) begin mag = ua - ub; sr = sa; end
    else               begin mag = ub - ua; sr = sb; end
    if (mag == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) begin
`ifdef FP_ADD_SUBNORMAL_EN
      return {sr, 8'd0, mag[22:0]};
`else
      return {sr, 31'd0};
`endif
    end
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag - (q << sh);
    half = (sh > 0) ? (300'd1 << (sh - 1)) : '0;
    if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
    e = p - 22;
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {sr, 8'hFF, 23'd0};
    return {sr, e[7:0], q[22:0]};
  endfunction

  // ---------------- driver ----------------
  // lat counts sampled edges after the Load edge until Valid is seen (20 = gave up)
  task automatic wait_valid(output logic [31:0] res, output int lat);
    lat = 0;
    while (!Valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    res = Result;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] res, output int lat);
    @(negedge Clk);
    Load = 1'b1; A = a; B = b; Op = op;
    @(negedge Clk);
    Load = 1'b0; A = $urandom; B = $urandom; Op = 1'($urandom_range(0, 1));
    wait_valid(res, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RstN = 1'b0; Load = 1'b0; A = '0; B = '0; Op = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++; if (Result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=%h", Result, 32'd0); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    RstN = 1'b1;
    repeat (2) @(negedge Clk);
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid got=%b exp=0", Valid); end
  endtask

  task automatic test_basic();
    int lat;
    @(negedge Clk);
    Load = 1'b1; A = 32'h3FC00000; B = 32'h3FC00000; Op = 1'b0;
    @(negedge Clk);
    Load = 1'b0;
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", Busy); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_low got=%b exp=0", Valid); end
    lat = 0;
    while (!Valid && lat < 20) begin @(negedge Clk); lat++; end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    n_cmp++; if (Result !== 32'h40400000) begin n_err++; $display("FAIL basic_result got=%h exp=40400000", Result); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got=%b exp=0", Busy); end
    A = $urandom; B = $urandom;
    repeat (5) @(negedge Clk);
    n_cmp++; if (Valid !== 1'b1 || Result !== 32'h40400000) begin
      n_err++; $display("FAIL basic_hold got=%b/%h exp=1/40400000", Valid, Result);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[14], tb[14], te[14], res;
    logic        to[14];
    int          lat;
    ta[0]  = 32'h3F800000; tb[0]  = 32'h3F800000; to[0]  = 1; te[0]  = 32'h00000000;
    ta[1]  = 32'h3F800000; tb[1]  = 32'h33800000; to[1]  = 0; te[1]  = 32'h3F800000;
    ta[2]  = 32'h3F800000; tb[2]  = 32'h33C00000; to[2]  = 0; te[2]  = 32'h3F800001;
    ta[3]  = 32'h7F7FFFFF; tb[3]  = 32'h7F7FFFFF; to[3]  = 0; te[3]  = 32'h7F800000;
    ta[4]  = 32'h7F800000; tb[4]  = 32'h7F800000; to[4]  = 1; te[4]  = 32'h7FC00000;
    ta[5]  = 32'h7FC00000; tb[5]  = 32'h3F800000; to[5]  = 0; te[5]  = 32'h7FC00000;
`ifdef FP_ADD_SUBNORMAL_EN
    ta[6]  = 32'h00000001; tb[6]  = 32'h00000001; to[6]  = 0; te[6]  = 32'h00000002;
`else
    ta[6]  = 32'h00000001; tb[6]  = 32'h00000001; to[6]  = 0; te[6]  = 32'h00000000;
`endif
    ta[7]  = 32'h80000000; tb[7]  = 32'h80000000; to[7]  = 0; te[7]  = 32'h80000000;
    ta[8]  = 32'h80000000; tb[8]  = 32'h00000000; to[8]  = 1; te[8]  = 32'h80000000;
    ta[9]  = 32'h00000000; tb[9]  = 32'h80000000; to[9]  = 0; te[9]  = 32'h00000000;
    ta[10] = 32'hFF800000; tb[10] = 32'h3F800000; to[10] = 0; te[10] = 32'hFF800000;
    ta[11] = 32'h3F800000; tb[11] = 32'h3F800001; to[11] = 1; te[11] = 32'hB4000000;
    ta[12] = 32'h40000000; tb[12] = 32'hC0400000; to[12] = 0; te[12] = 32'hBF800000;
    ta[13] = 32'h3F800000; tb[13] = 32'h7F800000; to[13] = 1; te[13] = 32'hFF800000;
    for (int i = 0; i < 14; i++) begin
      run_op(ta[i], tb[i], to[i], res, lat);
      n_cmp++;
      if (res !== te[i] || lat != 4) begin
        n_err++;
        $display("FAIL directed_%0d a=%h b=%h op=%b got=%h lat=%0d exp=%h lat=4",
                 i, ta[i], tb[i], to[i], res, lat, te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp_v;
    logic        op;
    int          lat;
    for (int n = 0; n < 400; n++) begin
      a  = $urandom;
      b  = $urandom;
      op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: b[30:23] = a[30:23] ^ 8'($urandom_range(0, 3));
        3:       b = a ^ {1'($urandom_range(0, 1)), 31'd0};
        4:       a[30:23] = 8'd0;
        5:       begin a[30:23] = 8'($urandom_range(100, 150)); b[30:23] = 8'($urandom_range(100, 150)); end
        6:       begin b[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) b[22:0] = '0; end
        7:       begin a[30:23] = 8'hFE; b[30:23] = 8'($urandom_range(250, 254)); end
        8:       begin a[30:23] = 8'($urandom_range(60, 200)); b[30:23] = a[30:23] - 8'($urandom_range(23, 26)); end
        default: ;
      endcase
      exp_v = ref_add(a, b, op);
      run_op(a, b, op, res, lat);
      n_cmp++;
      if (res !== exp_v || lat != 4) begin
        n_err++;
        $display("FAIL random_%0d a=%h b=%h op=%b got=%h lat=%0d exp=%h lat=4",
                 n, a, b, op, res, lat, exp_v);
      end
    end
  endtask

  task automatic test_restart();
    logic [31:0] res, exp_v;
    int          lat;
    exp_v = ref_add(32'h40A00000, 32'h3F800000, 1'b1);  // 5 - 1 = 4
    @(negedge Clk);
    Load = 1'b1; A = 32'h3FC00000; B = 32'h3FC00000; Op = 1'b0;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    Load = 1'b1; A = 32'h40A00000; B = 32'h3F800000; Op = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    wait_valid(res, lat);
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL restart_latency got=%0d exp=4", lat); end
    n_cmp++; if (res !== exp_v) begin n_err++; $display("FAIL restart_result got=%h exp=%h", res, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3], b[3], res, exp_v;
    int          lat;
    for (int i = 0; i < 3; i++) begin a[i] = $urandom; b[i] = $urandom; a[i][30] = 1'b0; b[i][30] = 1'b0; end
    exp_v = ref_add(a[2], b[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      Load = 1'b1; A = a[i]; B = b[i]; Op = 1'b0;
    end
    @(negedge Clk);
    Load = 1'b0;
    wait_valid(res, lat);
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    n_cmp++; if (res !== exp_v) begin n_err++; $display("FAIL b2b_result got=%h exp=%h", res, exp_v); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge Clk);
    Load = 1'b1; A = 32'h3F800000; B = 32'h40000000; Op = 1'b0;
    @(negedge Clk);
    Load = 1'b0;
    @(posedge Clk);
    #3 RstN = 1'b0;
    #1;
    n_cmp++; if (Result !== 32'd0 || Valid !== 1'b0 || Busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid got=%h/%b/%b exp=00000000/0/0", Result, Valid, Busy);
    end
    @(negedge Clk);
    RstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL reset_mid_no_valid got=%0d exp=0", seen); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_add_sub.md
# fp_add_sub

Multi-cycle IEEE-754 floating-point adder/subtractor with a Load/Valid request handshake. It is the adder service that FP_Divider drives through its DivToAddA/DivToAddB/DivToAddOp/DivToAddLoad outputs and AddValid/AddOut inputs. It also serves as the add/sub unit of the FPU top level. Latency is a fixed 4 cycles for every operand class, so the divider's iteration sequencing is deterministic.

## Interface
- PRECISION, 32, operand width; 32 gives EXP=8/MAN=23, 64 gives EXP=11/MAN=52; other values unsupported.
- Clk  input  1  rising-edge clock.
- RstN  input  1  asynchronous active-low reset.
- Load  input  1  request strobe; sampled high on a Clk edge starts an operation.
- A  input  PRECISION  operand A, captured on the Load edge.
- B  input  PRECISION  operand B, captured on the Load edge.
- Op  input  1  0 = A+B, 1 = A−B, captured on the Load edge.
- Result  output  PRECISION  rounded result; held stable while Valid=1.
- Valid  output  1  result ready; held until the next Load.
- Busy  output  1  high while an operation is in flight.

## Operation
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → IDLE.
- Load edge, any state: capture A, B and Op; effective sign_b = B.sign ^ Op. Set Valid=0 and Busy=1, classify operands, go to ALIGN. A Load in a non-IDLE state aborts the current operation and restarts.
- ALIGN: swap so the larger magnitude is first. Right-shift the smaller significand (hidden bit included) by the exponent difference. Keep guard, round and sticky bits; a shift ≥ MAN+3 leaves only sticky.
- ADD: add or subtract significands according to the effective signs. Result sign is the sign of the larger operand.
- NORM: on carry-out, shift right 1 and exponent +1. Otherwise left-shift by leading-zero count and decrement the exponent. Exact cancellation gives a +0 result.
- ROUND: round-to-nearest-even on guard/round/sticky. A mantissa carry from rounding increments the exponent. Write Result, set Valid=1 and Busy=0, go to IDLE.
- Special cases are decided on the Load edge and flow through the same 4 stages unchanged.
  - Any NaN input → 0x7FC00000 (PRECISION=32; 64-bit equivalent).
  - +inf plus −inf (effective) → quiet NaN.
  - inf plus finite → that inf.
  - ±0 plus ±0 → −0 only if both effective signs are negative, else +0.
- Overflow (exponent ≥ all-ones after normalize or round) → ±inf of result sign.

## Timing
- Reset (RstN low, asynchronous): state=IDLE, Result=0, Valid=0, Busy=0, operand registers cleared.
- Load sampled at edge k: Valid=0 and Busy=1 after edge k. Result and Valid=1 appear after edge k+4, Busy=0 at the same time.
- Result and Valid do not change between the ROUND edge and the next Load edge.
- Load held high for several cycles restarts on every edge. The result lands 4 edges after the last sampled Load.
- Reset asserted mid-operation discards it. No Valid pulse follows reset release.
- Inputs A, B and Op are don't-care except on Load edges.

## Configuration
- FP_ADD_SUBNORMAL_EN defined: subnormal inputs use an implicit 0 hidden bit and exponent 1. Results below the normal range are denormalized with gradual underflow and correct rounding.
- Not defined: subnormal inputs are treated as zero of the same sign. Results below the normal range flush to zero of the result sign. NORM limits its left shift accordingly.

## Test plan
- Load A=0x3FC00000 (1.5), B=0x3FC00000, Op=0 → after 4 cycles Result=0x40400000 (3.0), Valid=1. Valid was 0 during cycles 1–3 and stays 1 with Load low.
- A=0x3F800000 (1.0), B=0x3F800000, Op=1 → Result=0x00000000 (+0).
- Rounding tie: A=0x3F800000, B=0x33800000 (2^-24), Op=0 → 0x3F800000 (round to even). With B=0x33C00000 (1.5·2^-24) → 0x3F800001.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000.
  - 0x7FC00000 + 1.0 → 0x7FC00000.
- Subnormal: 0x00000001 + 0x00000001 → 0x00000002 with FP_ADD_SUBNORMAL_EN, 0x00000000 without.
- Control boundaries:
  - Load a second request 2 cycles into an operation → only the second result appears, 4 cycles after its Load.
  - Assert RstN low mid-operation → Result=0, Valid=0 immediately, no later Valid.
